// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe controller: FSM states,
// winner codes and the eight winning-line masks.
package ttt_pkg;

    localparam int unsigned N_SLOTS = 9;
    localparam int unsigned N_LINES = 8;

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_BLUE = 2'b01,
        W_RED  = 2'b10,
        W_DRAW = 2'b11
    } winner_e;

    // Rows, columns, then the two diagonals.
    localparam logic [8:0] WIN_LINES [0:7] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    // Mask of the lowest-index line fully owned by board, or zero.
    function automatic logic [8:0] first_win_line(input logic [8:0] board);
        logic [8:0] line;
        line = '0;
        for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                line = WIN_LINES[i];
            end
        end
        return line;
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_next_free.sv
// Circular free-slot search: the first unoccupied slot after start (start
// itself excluded), wrapping 8 -> 0.
module ttt_next_free
    import ttt_pkg::*;
(
    input  logic [8:0] occupied,
    input  logic [8:0] start,
    output logic [8:0] next_oh,
    output logic       found
);

    logic [3:0] start_idx;
    logic [3:0] idx;

    always_comb begin
        start_idx = '0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (start[i]) start_idx = 4'(i);
        end
        next_oh = '0;
        found   = 1'b0;
        idx     = '0;
        // Walk distances downward so the nearest free slot is the one kept.
        for (int d = int'(N_SLOTS) - 1; d >= 1; d--) begin
            idx = 4'((int'(start_idx) + d) % int'(N_SLOTS));
            if (!occupied[idx]) begin
                next_oh = 9'(1) << idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: board, cursor, turn, win/draw detection and
// blink timebase. Define TTT_WIN_FLASH_EN to flash the winning line.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_place,
    input  logic       btn_new,
    output logic       blink,
    output logic [8:0] one_hot_current,
    output logic       c_player,
    output logic [8:0] blue,
    output logic [8:0] red,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned CW = $clog2(BLINK_HALF);

    state_e     state_q, state_d;
    winner_e    winner_q, winner_d;
    logic [8:0] blue_q, blue_d, red_q, red_d, cursor_q, cursor_d;
    logic       c_player_q, c_player_d, game_over_q, game_over_d;
    logic       blink_q, blink_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef TTT_WIN_FLASH_EN
    logic [8:0] line_q, line_d;
`endif

    logic [8:0] occupied, mover, win_mask, nf_next;
    logic       nf_found;

    assign occupied = blue_q | red_q;
    assign mover    = c_player_q ? red_q : blue_q;
    assign win_mask = first_win_line(mover);

    // One search serves both btn_next and the post-move cursor advance.
    ttt_next_free u_next_free (
        .occupied (occupied),
        .start    (cursor_q),
        .next_oh  (nf_next),
        .found    (nf_found)
    );

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        blue_d      = blue_q;
        red_d       = red_q;
        cursor_d    = cursor_q;
        c_player_d  = c_player_q;
        game_over_d = game_over_q;
        blink_d     = blink_q;
        cnt_d       = cnt_q + CW'(1);
`ifdef TTT_WIN_FLASH_EN
        line_d      = line_q;
`endif
        if (cnt_q == CW'(BLINK_HALF - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end

        if (btn_new) begin
            state_d     = S_PLAY;
            winner_d    = W_NONE;
            blue_d      = '0;
            red_d       = '0;
            cursor_d    = 9'h001;
            c_player_d  = 1'b0;
            game_over_d = 1'b0;
`ifdef TTT_WIN_FLASH_EN
            line_d      = '0;
`endif
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (btn_place) begin
                        if ((occupied & cursor_q) == '0) begin
                            if (c_player_q) red_d  = red_q | cursor_q;
                            else            blue_d = blue_q | cursor_q;
                            state_d = S_CHECK;
                        end
                    end else if (btn_next && nf_found) begin
                        cursor_d = nf_next;
                    end
                end
                S_CHECK: begin
                    if (win_mask != '0) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = c_player_q ? W_RED : W_BLUE;
                        cursor_d    = '0;
`ifdef TTT_WIN_FLASH_EN
                        line_d      = win_mask;
`endif
                    end else if (&occupied) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = W_DRAW;
                        cursor_d    = '0;
                    end else begin
                        state_d    = S_PLAY;
                        c_player_d = ~c_player_q;
                        cursor_d   = nf_next;
                    end
                end
                S_OVER: begin
                end
                default: state_d = S_PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLAY;
            winner_q    <= W_NONE;
            blue_q      <= '0;
            red_q       <= '0;
            cursor_q    <= 9'h001;
            c_player_q  <= 1'b0;
            game_over_q <= 1'b0;
            blink_q     <= 1'b0;
            cnt_q       <= '0;
`ifdef TTT_WIN_FLASH_EN
            line_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            blue_q      <= blue_d;
            red_q       <= red_d;
            cursor_q    <= cursor_d;
            c_player_q  <= c_player_d;
            game_over_q <= game_over_d;
            blink_q     <= blink_d;
            cnt_q       <= cnt_d;
`ifdef TTT_WIN_FLASH_EN
            line_q      <= line_d;
`endif
        end
    end

`ifdef TTT_WIN_FLASH_EN
    // line_q is only non-zero after a win, so draws and play stay steady.
    logic [8:0] dim;
    assign dim  = line_q & {9{~blink_q}};
    assign blue = (winner_q == W_BLUE) ? (blue_q & ~dim) : blue_q;
    assign red  = (winner_q == W_RED)  ? (red_q  & ~dim) : red_q;
`else
    assign blue = blue_q;
    assign red  = red_q;
`endif

    assign blink           = blink_q;
    assign one_hot_current = cursor_q;
    assign c_player        = c_player_q;
    assign game_over       = game_over_q;
    assign winner          = winner_q;

endmodule
